// File: rtl/rv32_pkg.sv
// Shared RV32 definitions: load/store unit states and fun3 access encodings.
package rv32_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2,
        DONE = 2'd3
    } lsu_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

endpackage

// File: rtl/lsu_align.sv
// Combinational data-path helpers for the load/store unit.
// Request side: legality/alignment check, store lane replication and byte enables.
// Response side: byte/half extraction and sign/zero extension of the raw read word,
// driven from the size/offset captured when the access was accepted.
module lsu_align
    import rv32_pkg::*;
(
    input  logic        i_load,
    input  logic        i_store,
    input  logic [2:0]  i_fun3,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_wdata,
    input  logic [2:0]  i_rd_fun3,
    input  logic [1:0]  i_rd_addr_lo,
    input  logic [31:0] i_rdata,
    output logic        o_legal,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_rdata
);

    logic w_fun3_ok;
    logic w_align_ok;

    // Legal only for exactly one of load/store, a known size encoding and natural alignment.
    always_comb begin
        w_fun3_ok  = 1'b0;
        w_align_ok = 1'b0;
        if (i_load) begin
            case (i_fun3)
                F3_B, F3_H, F3_W, F3_BU, F3_HU: w_fun3_ok = 1'b1;
                default:                        w_fun3_ok = 1'b0;
            endcase
        end else if (i_store) begin
            case (i_fun3)
                F3_B, F3_H, F3_W: w_fun3_ok = 1'b1;
                default:          w_fun3_ok = 1'b0;
            endcase
        end
        case (i_fun3[1:0])
            2'b00:   w_align_ok = 1'b1;
            2'b01:   w_align_ok = ~i_addr_lo[0];
            2'b10:   w_align_ok = (i_addr_lo == 2'b00);
            default: w_align_ok = 1'b0;
        endcase
        o_legal = (i_load ^ i_store) & w_fun3_ok & w_align_ok;
    end

    // Replicate store data into every lane and select lanes with byte enables; loads reuse the enables.
    always_comb begin
        o_wdata = i_wdata;
        o_be    = 4'b1111;
        case (i_fun3[1:0])
            2'b00: begin
                o_wdata = {4{i_wdata[7:0]}};
                o_be    = 4'b0001 << i_addr_lo;
            end
            2'b01: begin
                o_wdata = {2{i_wdata[15:0]}};
                o_be    = 4'b0011 << {i_addr_lo[1], 1'b0};
            end
            default: begin
                o_wdata = i_wdata;
                o_be    = 4'b1111;
            end
        endcase
    end

    logic [31:0] w_byte_sh;
    logic [31:0] w_half_sh;

    // Shift the addressed byte/half down to bit 0, then extend according to the load kind.
    always_comb begin
        w_byte_sh = i_rdata >> {i_rd_addr_lo, 3'b000};
        w_half_sh = i_rdata >> {i_rd_addr_lo[1], 4'b0000};
        case (i_rd_fun3)
            F3_B:    o_rdata = {{24{w_byte_sh[7]}}, w_byte_sh[7:0]};
            F3_BU:   o_rdata = {24'd0, w_byte_sh[7:0]};
            F3_H:    o_rdata = {{16{w_half_sh[15]}}, w_half_sh[15:0]};
            F3_HU:   o_rdata = {16'd0, w_half_sh[15:0]};
            default: o_rdata = i_rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory access stage: accepts a decoded load/store, runs a req/gnt/rvalid
// transaction on the data-memory port while stalling the core, and returns the
// aligned, extended load result for write-back.
module load_store_unit
    import rv32_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic              store_i,
    input  logic [2:0]        fun3_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       wdata_i,
    output logic              stall_o,
    output logic              done_o,
    output logic              misalign_o,
    output logic [31:0]       rdata_o,
    output logic              dmem_req_o,
    output logic              dmem_we_o,
    output logic [ADDR_W-1:0] dmem_addr_o,
    output logic [31:0]       dmem_wdata_o,
    output logic [3:0]        dmem_be_o,
    input  logic              dmem_gnt_i,
    input  logic              dmem_rvalid_i,
    input  logic [31:0]       dmem_rdata_i
);

    lsu_state_t        r_state;
    lsu_state_t        w_next;
    logic [ADDR_W-1:0] r_addr;
    logic [2:0]        r_fun3;
    logic              r_we;
    logic [31:0]       r_wdata;
    logic [3:0]        r_be;
    logic [31:0]       r_rdata;

    logic              w_legal;
    logic [3:0]        w_be;
    logic [31:0]       w_wdata;
    logic [31:0]       w_load_ext;
    logic              w_accept;
    logic              w_capture;

    lsu_align u_align (
        .i_load       (load_i),
        .i_store      (store_i),
        .i_fun3       (fun3_i),
        .i_addr_lo    (addr_i[1:0]),
        .i_wdata      (wdata_i),
        .i_rd_fun3    (r_fun3),
        .i_rd_addr_lo (r_addr[1:0]),
        .i_rdata      (dmem_rdata_i),
        .o_legal      (w_legal),
        .o_be         (w_be),
        .o_wdata      (w_wdata),
        .o_rdata      (w_load_ext)
    );

    // Next-state and control outputs; rvalid only matters while a load is in REQ or RESP.
    always_comb begin
        w_next     = r_state;
        w_accept   = 1'b0;
        w_capture  = 1'b0;
        stall_o    = 1'b0;
        done_o     = 1'b0;
        misalign_o = 1'b0;
        dmem_req_o = 1'b0;
        case (r_state)
            IDLE: begin
                if (load_i | store_i) begin
                    if (w_legal) begin
                        w_accept = 1'b1;
                        stall_o  = 1'b1;
                        w_next   = REQ;
                    end else begin
                        misalign_o = 1'b1;
                    end
                end
            end
            REQ: begin
                dmem_req_o = 1'b1;
                stall_o    = 1'b1;
                if (dmem_gnt_i) begin
                    if (r_we) begin
                        w_next = DONE;
                    end else if (dmem_rvalid_i) begin
                        w_capture = 1'b1;
                        w_next    = DONE;
                    end else begin
                        w_next = RESP;
                    end
                end
            end
            RESP: begin
                stall_o = 1'b1;
                if (dmem_rvalid_i) begin
                    w_capture = 1'b1;
                    w_next    = DONE;
                end
            end
            DONE: begin
                done_o = 1'b1;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // State register; reset abandons any outstanding request immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // Capture the request on acceptance so the bus outputs stay stable until granted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr  <= '0;
            r_fun3  <= 3'b000;
            r_we    <= 1'b0;
            r_wdata <= 32'd0;
            r_be    <= 4'b0000;
        end else if (w_accept) begin
            r_addr  <= addr_i;
            r_fun3  <= fun3_i;
            r_we    <= store_i;
            r_wdata <= w_wdata;
            r_be    <= w_be;
        end
    end

    // Load result register; only a completing load updates it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)            r_rdata <= 32'd0;
        else if (w_capture) r_rdata <= w_load_ext;
    end

    assign rdata_o      = r_rdata;
    assign dmem_we_o    = r_we;
    assign dmem_be_o    = r_be;
    assign dmem_wdata_o = r_wdata;
    assign dmem_addr_o  = {r_addr[ADDR_W-1:2], 2'b00};

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: a vector table of accesses with
// per-vector bus timing, a scoreboard queue of expected results, and hand
// sequences for mid-access reset and back-to-back loads.
module tb_load_store_unit;
    import rv32_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_i, store_i;
    logic [2:0]  fun3_i;
    logic [31:0] addr_i, wdata_i;
    logic        stall_o, done_o, misalign_o;
    logic [31:0] rdata_o;
    logic        dmem_req_o, dmem_we_o;
    logic [31:0] dmem_addr_o, dmem_wdata_o;
    logic [3:0]  dmem_be_o;
    logic        dmem_gnt_i, dmem_rvalid_i;
    logic [31:0] dmem_rdata_i;

    load_store_unit #(.ADDR_W(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .load_i        (load_i),
        .store_i       (store_i),
        .fun3_i        (fun3_i),
        .addr_i        (addr_i),
        .wdata_i       (wdata_i),
        .stall_o       (stall_o),
        .done_o        (done_o),
        .misalign_o    (misalign_o),
        .rdata_o       (rdata_o),
        .dmem_req_o    (dmem_req_o),
        .dmem_we_o     (dmem_we_o),
        .dmem_addr_o   (dmem_addr_o),
        .dmem_wdata_o  (dmem_wdata_o),
        .dmem_be_o     (dmem_be_o),
        .dmem_gnt_i    (dmem_gnt_i),
        .dmem_rvalid_i (dmem_rvalid_i),
        .dmem_rdata_i  (dmem_rdata_i)
    );

    always #5 clk = ~clk;

    int cycleCnt = 0;
    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    typedef struct {
        logic        isLoad;
        logic        isStore;
        logic [2:0]  fun3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] memWord;
        int          gntDelay;
        int          rvDelay;
        logic        expMis;
        logic [31:0] expRdata;
        logic [31:0] expWdata;
        logic [3:0]  expBe;
    } vec_t;

    typedef struct {
        logic        mis;
        int          reqCycles;
        int          stallCycles;
        logic        done;
        logic [31:0] rdata;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        we;
        logic [31:0] addr;
        logic        chkWdata;
    } exp_t;

    typedef struct {
        int          misCycles;
        int          reqCycles;
        int          stallCycles;
        logic        done;
        logic        stable;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        we;
        logic [31:0] addr;
        int          doneCycle;
    } act_t;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] modelRdata = 32'd0;
    exp_t        expQ[$];
    act_t        lastAct;
    vec_t        vecs[14];

    function automatic vec_t mkVec(input logic ld, input logic st, input logic [2:0] f3,
                                   input logic [31:0] ad, input logic [31:0] wd, input logic [31:0] mw,
                                   input int gd, input int rd, input logic mis,
                                   input logic [31:0] er, input logic [31:0] ew, input logic [3:0] eb);
        vec_t v;
        v.isLoad = ld;  v.isStore = st;  v.fun3 = f3;     v.addr = ad;
        v.wdata = wd;   v.memWord = mw;  v.gntDelay = gd; v.rvDelay = rd;
        v.expMis = mis; v.expRdata = er; v.expWdata = ew; v.expBe = eb;
        return v;
    endfunction

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    // Drive one access, act as the memory with the vector's timing, and record what the DUT did.
    task automatic applyStimulus(input vec_t v);
        exp_t e;
        act_t a;
        bit   respWait;
        int   respCnt;
        e.mis         = v.expMis;
        e.reqCycles   = v.expMis ? 0 : v.gntDelay + 1;
        e.stallCycles = v.expMis ? 0 : 2 + v.gntDelay + ((v.isLoad && v.rvDelay > 0) ? v.rvDelay : 0);
        e.done        = !v.expMis;
        if (v.isLoad && !v.isStore && !v.expMis) modelRdata = v.expRdata;
        e.rdata       = modelRdata;
        e.wdata       = v.expWdata;
        e.be          = v.expBe;
        e.we          = v.isStore;
        e.addr        = {v.addr[31:2], 2'b00};
        e.chkWdata    = v.isStore;
        expQ.push_back(e);

        a = '{default: 0};
        a.stable = 1'b1;
        respWait = 0;
        respCnt  = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            if (cyc == 0) begin
                load_i = v.isLoad; store_i = v.isStore; fun3_i = v.fun3;
                addr_i = v.addr;   wdata_i = v.wdata;
            end else begin
                load_i = 1'b0; store_i = 1'b0; fun3_i = 3'b000; addr_i = 32'd0; wdata_i = 32'd0;
            end
            dmem_gnt_i    = 1'b0;
            dmem_rvalid_i = 1'b0;
            dmem_rdata_i  = $urandom;
            if (dmem_req_o) begin
                if (a.reqCycles == 0) begin
                    a.be = dmem_be_o; a.wdata = dmem_wdata_o; a.we = dmem_we_o; a.addr = dmem_addr_o;
                end else if (a.be !== dmem_be_o || a.wdata !== dmem_wdata_o ||
                             a.we !== dmem_we_o || a.addr !== dmem_addr_o) begin
                    a.stable = 1'b0;
                end
                a.reqCycles++;
                if (a.reqCycles > v.gntDelay) begin
                    dmem_gnt_i = 1'b1;
                    if (v.isLoad) begin
                        if (v.rvDelay == 0) begin
                            dmem_rvalid_i = 1'b1;
                            dmem_rdata_i  = v.memWord;
                        end else begin
                            respWait = 1;
                        end
                    end
                end
            end else if (respWait) begin
                respCnt++;
                if (respCnt >= v.rvDelay) begin
                    dmem_rvalid_i = 1'b1;
                    dmem_rdata_i  = v.memWord;
                    respWait      = 0;
                end
            end
            #1;
            if (stall_o)    a.stallCycles++;
            if (misalign_o) a.misCycles++;
            if (done_o) begin
                a.done      = 1'b1;
                a.doneCycle = cycleCnt;
                break;
            end
            if (v.expMis && cyc >= 3) break;
        end
        lastAct = a;
    endtask

    // Pop the expected result for the access just run and compare it with what was observed.
    task automatic checkOutput(input string tag);
        exp_t e;
        if (expQ.size() == 0) begin
            checkVal({tag, "_scoreboard_empty"}, 32'd1, 32'd0);
            return;
        end
        e = expQ.pop_front();
        checkVal({tag, "_misalign_cycles"}, lastAct.misCycles, e.mis ? 32'd1 : 32'd0);
        checkVal({tag, "_req_cycles"}, lastAct.reqCycles, e.reqCycles);
        checkVal({tag, "_stall_cycles"}, lastAct.stallCycles, e.stallCycles);
        checkVal({tag, "_done"}, {31'd0, lastAct.done}, {31'd0, e.done});
        checkVal({tag, "_rdata"}, rdata_o, e.rdata);
        if (!e.mis) begin
            checkVal({tag, "_be"}, {28'd0, lastAct.be}, {28'd0, e.be});
            checkVal({tag, "_we"}, {31'd0, lastAct.we}, {31'd0, e.we});
            checkVal({tag, "_addr"}, lastAct.addr, e.addr);
            checkVal({tag, "_bus_stable"}, {31'd0, lastAct.stable}, 32'd1);
            if (e.chkWdata) checkVal({tag, "_wdata"}, lastAct.wdata, e.wdata);
        end
    endtask

    initial begin
        int t1;
        int t2;
        rst = 1'b1;
        load_i = 1'b0; store_i = 1'b0; fun3_i = 3'b000; addr_i = 32'd0; wdata_i = 32'd0;
        dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_rdata_i = 32'd0;

        vecs[0]  = mkVec(0, 1, F3_W,   32'h100, 32'hDEADBEEF, 32'h0,        2, 0, 0, 32'h0,        32'hDEADBEEF, 4'b1111);
        vecs[1]  = mkVec(1, 0, F3_B,   32'h103, 32'h0,        32'h80FF0000, 0, 0, 0, 32'hFFFFFF80, 32'h0,        4'b1000);
        vecs[2]  = mkVec(1, 0, F3_BU,  32'h103, 32'h0,        32'h80FF0000, 0, 0, 0, 32'h00000080, 32'h0,        4'b1000);
        vecs[3]  = mkVec(0, 1, F3_H,   32'h102, 32'h1234ABCD, 32'h0,        1, 0, 0, 32'h0,        32'hABCDABCD, 4'b1100);
        vecs[4]  = mkVec(1, 0, F3_HU,  32'h102, 32'h0,        32'hABCD0000, 0, 2, 0, 32'h0000ABCD, 32'h0,        4'b1100);
        vecs[5]  = mkVec(1, 0, F3_W,   32'h101, 32'h0,        32'h0,        0, 0, 1, 32'h0,        32'h0,        4'b0000);
        vecs[6]  = mkVec(0, 1, F3_H,   32'h003, 32'h55AA55AA, 32'h0,        0, 0, 1, 32'h0,        32'h0,        4'b0000);
        vecs[7]  = mkVec(1, 0, 3'b110, 32'h100, 32'h0,        32'h0,        0, 0, 1, 32'h0,        32'h0,        4'b0000);
        vecs[8]  = mkVec(1, 1, F3_W,   32'h100, 32'h0,        32'h0,        0, 0, 1, 32'h0,        32'h0,        4'b0000);
        vecs[9]  = mkVec(1, 0, F3_H,   32'h200, 32'h0,        32'h00008001, 0, 1, 0, 32'hFFFF8001, 32'h0,        4'b0011);
        vecs[10] = mkVec(0, 1, F3_B,   32'h201, 32'h000000A5, 32'h0,        0, 0, 0, 32'h0,        32'hA5A5A5A5, 4'b0010);
        vecs[11] = mkVec(1, 0, F3_W,   32'h204, 32'h0,        32'hCAFEF00D, 1, 0, 0, 32'hCAFEF00D, 32'h0,        4'b1111);
        vecs[12] = mkVec(0, 1, 3'b011, 32'h000, 32'h0,        32'h0,        0, 0, 1, 32'h0,        32'h0,        4'b0000);
        vecs[13] = mkVec(1, 0, F3_B,   32'h202, 32'h0,        32'h007F0000, 0, 0, 0, 32'h0000007F, 32'h0,        4'b0100);

        #2;
        checkVal("reset_ctrl", {23'd0, stall_o, done_o, misalign_o, dmem_req_o, dmem_we_o, dmem_be_o}, 32'd0);
        checkVal("reset_rdata", rdata_o, 32'd0);
        checkVal("reset_addr", dmem_addr_o, 32'd0);
        checkVal("reset_wdata", dmem_wdata_o, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 14; i++) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("vec%0d", i));
        end

        // Reset while a load waits in RESP: outputs clear at once, a late rvalid is ignored.
        @(negedge clk);
        load_i = 1'b1; fun3_i = F3_W; addr_i = 32'h200;
        @(negedge clk);
        load_i = 1'b0; addr_i = 32'd0; fun3_i = 3'b000;
        checkVal("rst_seq_in_req", {31'd0, dmem_req_o}, 32'd1);
        dmem_gnt_i = 1'b1;
        @(negedge clk);
        dmem_gnt_i = 1'b0;
        checkVal("rst_seq_in_resp", {30'd0, dmem_req_o, stall_o}, 32'd1);
        #2 rst = 1'b1;
        #1;
        checkVal("rst_async_ctrl", {23'd0, stall_o, done_o, misalign_o, dmem_req_o, dmem_we_o, dmem_be_o}, 32'd0);
        checkVal("rst_async_rdata", rdata_o, 32'd0);
        modelRdata = 32'd0;
        @(negedge clk);
        rst = 1'b0;
        dmem_rvalid_i = 1'b1;
        dmem_rdata_i  = 32'h5555AAAA;
        #1;
        checkVal("late_rvalid_stall", {31'd0, stall_o}, 32'd0);
        @(negedge clk);
        dmem_rvalid_i = 1'b0;
        #1;
        checkVal("late_rvalid_ignored", {30'd0, done_o, stall_o}, 32'd0);
        checkVal("late_rvalid_rdata", rdata_o, 32'd0);

        // Reset while the request is still being offered: req must drop without a clock edge.
        @(negedge clk);
        load_i = 1'b1; fun3_i = F3_W; addr_i = 32'h300;
        @(negedge clk);
        load_i = 1'b0; addr_i = 32'd0; fun3_i = 3'b000;
        #2 rst = 1'b1;
        #1;
        checkVal("rst_in_req_drop", {30'd0, dmem_req_o, stall_o}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Back-to-back word loads: second accepted right after the first DONE.
        applyStimulus(mkVec(1, 0, F3_W, 32'h300, 32'h0, 32'h11112222, 0, 0, 0, 32'h11112222, 32'h0, 4'b1111));
        t1 = lastAct.doneCycle;
        checkOutput("b2b_first");
        applyStimulus(mkVec(1, 0, F3_W, 32'h304, 32'h0, 32'h33334444, 0, 0, 0, 32'h33334444, 32'h0, 4'b1111));
        t2 = lastAct.doneCycle;
        checkOutput("b2b_second");
        checkVal("b2b_done_spacing", t2 - t1, 32'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
